id_pipe: RTL and testbench
==========================

Name: id_pipe

Overview:
- Parametrised successor to the combinational decode stage: decodes I, R, LUI, AUIPC and LOAD instructions and forwards operands from FWD_STAGES downstream stages.
- Adds behaviour the earlier stage lacks: load-use hazard detection with stall and bubble, a registered ID/EX output with valid/ready backpressure, flush, x0-safe forwarding, and a saturating stall counter.
- Sits between the IF/ID register and EX.

Parameters:
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, instruction and register data width
- RADDR_WIDTH, 5, register index width
- FWD_STAGES, 2, number of forwarding sources; index 0 is the youngest (EX) and has the highest priority
- CNT_WIDTH, 16, stall counter width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset
- inst_valid_i  in  1  inst_i/inst_addr_i valid
- inst_addr_i  in  ADDR_WIDTH  PC of inst_i
- inst_i  in  DATA_WIDTH  instruction
- reg1_rdata_i  in  DATA_WIDTH  regfile port 1 data
- reg2_rdata_i  in  DATA_WIDTH  regfile port 2 data
- fwd_we_i  in  FWD_STAGES  per-stage write enable
- fwd_waddr_i  in  FWD_STAGES*RADDR_WIDTH  per-stage dest; stage k at bits [k*RADDR_WIDTH +: RADDR_WIDTH]
- fwd_wdata_i  in  FWD_STAGES*DATA_WIDTH  per-stage result, same packing
- fwd_pend_i  in  FWD_STAGES  stage result not yet available (load in flight)
- ex_ready_i  in  1  EX accepts the ID/EX register this cycle
- flush_i  in  1  discard the current and held instruction
- reg1_raddr_o  out  RADDR_WIDTH  regfile port 1 address (combinational)
- reg2_raddr_o  out  RADDR_WIDTH  regfile port 2 address (combinational)
- reg1_re_o  out  1  port 1 read enable (combinational)
- reg2_re_o  out  1  port 2 read enable (combinational)
- stall_o  out  1  hold IF/ID this cycle (combinational)
- id_valid_o  out  1  ID/EX register holds a valid instruction
- inst_o  out  DATA_WIDTH  registered instruction
- inst_addr_o  out  ADDR_WIDTH  registered PC
- op1_o  out  DATA_WIDTH  registered operand 1
- op2_o  out  DATA_WIDTH  registered operand 2
- reg_we_o  out  1  registered write enable
- reg_waddr_o  out  RADDR_WIDTH  registered destination
- is_load_o  out  1  registered load flag; feeds fwd_pend_i of the next stage
- stall_cnt_o  out  CNT_WIDTH  saturating count of hazard-stall cycles

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge):
  - id_valid_o=0, inst_o=NOP (0x00000013).
  - inst_addr_o, op1_o, op2_o, reg_waddr_o, stall_cnt_o = 0.
  - reg_we_o=0, is_load_o=0.
  - Reset aborts any stall or hold in progress.
- Decode (combinational):
  - I: op1=rs1, op2=sext(imm[31:20]).
  - R: op1=rs1, op2=rs2.
  - LUI: op1={imm[31:12],12'b0}, op2=0.
  - AUIPC: op1=inst_addr_i, op2={imm[31:12],12'b0}.
  - LOAD: op1=rs1, op2=sext(imm), is_load=1.
  - Unknown opcode or inst_valid_i=0: decode as NOP with all enables 0.
- Forwarding, per operand with re=1:
  - Scan stages 0..FWD_STAGES-1 for fwd_we_i[k]=1 and fwd_waddr_i[k]==raddr; the first match wins.
  - Use fwd_wdata_i[k]; with no match, use regfile data.
  - raddr==0 never forwards; the operand is 0.
- Hazard:
  - hazard = inst_valid_i & (a winning match for either operand has fwd_pend_i[k]=1).
  - A pending match at a lower index shadows a non-pending older match.
- Register update, load = !id_valid_o | ex_ready_i:
  - flush_i=1: id_valid_o<=0, inst_o<=NOP, reg_we_o<=0, is_load_o<=0. Flush overrides load, hold, and hazard.
  - Else load=1 and hazard=1: insert a bubble (same values as flush).
  - Else load=1: capture the decoded instruction; id_valid_o<=inst_valid_i.
  - Else (load=0): hold all registers.
- stall_o = !flush_i & inst_valid_i & (hazard | !load).
- stall_cnt_o: increments when hazard=1 and flush_i=0; saturates at all-ones and does not wrap.
- Latency: one cycle from an accepted inst_i to id_valid_o.
- The hazard check re-evaluates every cycle, so a pending result that resolves releases the stall on the next cycle.

Decomposition:
- Shared package (defines.v):
  - Opcodes INST_TYPE_I, INST_TYPE_R_M, INST_TYPE_LUI, INST_TYPE_AUIPC, INST_TYPE_L.
  - NOP, ZERO_REG, ZERO.
  - READ_ENABLE/READ_DISABLE, WRITE_ENABLE/WRITE_DISABLE.
- Sub-module id_fwd_mux (instantiated twice):
  - Inputs: raddr, re, rdata, and the packed forwarding buses.
  - Outputs: operand value and pending flag.

Test Plan:
1. Reset → id_valid_o=0, inst_o=0x00000013, stall_cnt_o=0. Then addi x1,x0,5 with ex_ready_i=1 → next cycle op1_o=0, op2_o=5, reg_waddr_o=1, reg_we_o=1.
2. add x3,x1,x2 with stage0 (x1=0xA) and stage1 (x1=0xB) both writing x1 → op1_o=0xA. With stage0 disabled → op1_o=0xB.
3. Stage0 writes x0=0xFF; addi x2,x0,1 → op1_o=0, no forward.
4. lw x5 with stage0 fwd_pend_i=1, then add x6,x5,x5 → stall_o=1 for one cycle, id_valid_o=0 (bubble), stall_cnt_o=1. Next cycle with pend=0 and wdata=0x77 → op1_o=op2_o=0x77.
5. ex_ready_i=0 for 3 cycles with id_valid_o=1 → outputs held, stall_o=1, stall_cnt_o unchanged.
6. flush_i=1 during a hazard stall → next cycle id_valid_o=0, stall_o=0 in the flush cycle. rst_n_i=0 mid-hold → all outputs return to reset values.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: constants and decode helpers shared by the instruction-decode
// stage (id_pipe) and its forwarding mux (id_fwd_mux).
//   - RV32 base opcodes recognised by the decoder
//   - canonical NOP, zero register / zero value
//   - read/write enable encodings
//   - inst_cls_e + classify(): opcode -> instruction class
package id_pipe_pkg;

    localparam logic [6:0]  INST_TYPE_I     = 7'b0010011;
    localparam logic [6:0]  INST_TYPE_R_M   = 7'b0110011;
    localparam logic [6:0]  INST_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0]  INST_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0]  INST_TYPE_L     = 7'b0000011;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ZERO     = 32'h0000_0000;
    localparam int unsigned ZERO_REG = 0;

    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_I,
        CLS_R,
        CLS_LUI,
        CLS_AUIPC,
        CLS_LOAD
    } inst_cls_e;

    function automatic inst_cls_e classify(input logic [6:0] opcode);
        inst_cls_e cls;
        case (opcode)
            INST_TYPE_I:     cls = CLS_I;
            INST_TYPE_R_M:   cls = CLS_R;
            INST_TYPE_LUI:   cls = CLS_LUI;
            INST_TYPE_AUIPC: cls = CLS_AUIPC;
            INST_TYPE_L:     cls = CLS_LOAD;
            default:         cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/id_pipe_fwd_mux.sv
// id_fwd_mux: operand source select for one register read port.
// Ports:
//   raddr     in   register index being read
//   re        in   read enable; when low the operand is zero
//   rdata     in   register file data for raddr
//   fwd_we    in   per-stage write enable
//   fwd_waddr in   per-stage destination, stage k at [k*RADDR_WIDTH +: RADDR_WIDTH]
//   fwd_wdata in   per-stage result, stage k at [k*DATA_WIDTH +: DATA_WIDTH]
//   fwd_pend  in   per-stage "result not yet available"
//   data      out  selected operand
//   pend      out  winning source is still pending
module id_fwd_mux
    import id_pipe_pkg::*;
#(
    parameter int RADDR_WIDTH = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int FWD_STAGES  = 2
) (
    input  logic [RADDR_WIDTH-1:0]            raddr,
    input  logic                              re,
    input  logic [DATA_WIDTH-1:0]             rdata,
    input  logic [FWD_STAGES-1:0]             fwd_we,
    input  logic [FWD_STAGES*RADDR_WIDTH-1:0] fwd_waddr,
    input  logic [FWD_STAGES*DATA_WIDTH-1:0]  fwd_wdata,
    input  logic [FWD_STAGES-1:0]             fwd_pend,
    output logic [DATA_WIDTH-1:0]             data,
    output logic                              pend
);

    always_comb begin
        data = rdata;
        pend = 1'b0;
        if (!re || raddr == RADDR_WIDTH'(ZERO_REG)) begin
            data = '0;
        end else begin
            // Walk oldest to youngest so the lowest-index (youngest) match is
            // the last assignment and therefore wins, pending flag included.
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (fwd_we[k] && fwd_waddr[k*RADDR_WIDTH +: RADDR_WIDTH] == raddr) begin
                    data = fwd_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                    pend = fwd_pend[k];
                end
            end
        end
    end

endmodule

// File: rtl/id_pipe.sv
// id_pipe: instruction decode stage between the IF/ID register and EX.
// Decodes I / R / LUI / AUIPC / LOAD, forwards operands from FWD_STAGES
// downstream stages, detects load-use hazards (stall + bubble) and holds a
// registered ID/EX slot under valid/ready backpressure with flush.
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   inst_valid_i/addr_i/i     instruction from IF/ID
//   reg1/2_rdata_i            register file read data
//   fwd_we/waddr/wdata/pend_i packed forwarding sources, index 0 youngest
//   ex_ready_i                EX accepts the ID/EX slot this cycle
//   flush_i                   drop the current and held instruction
//   reg1/2_raddr_o, _re_o     register file read request (combinational)
//   stall_o                   hold IF/ID (combinational)
//   id_valid_o ... is_load_o  registered ID/EX slot
//   stall_cnt_o               saturating count of hazard cycles
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int FWD_STAGES  = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              inst_valid_i,
    input  logic [ADDR_WIDTH-1:0]             inst_addr_i,
    input  logic [DATA_WIDTH-1:0]             inst_i,
    input  logic [DATA_WIDTH-1:0]             reg1_rdata_i,
    input  logic [DATA_WIDTH-1:0]             reg2_rdata_i,
    input  logic [FWD_STAGES-1:0]             fwd_we_i,
    input  logic [FWD_STAGES*RADDR_WIDTH-1:0] fwd_waddr_i,
    input  logic [FWD_STAGES*DATA_WIDTH-1:0]  fwd_wdata_i,
    input  logic [FWD_STAGES-1:0]             fwd_pend_i,
    input  logic                              ex_ready_i,
    input  logic                              flush_i,
    output logic [RADDR_WIDTH-1:0]            reg1_raddr_o,
    output logic [RADDR_WIDTH-1:0]            reg2_raddr_o,
    output logic                              reg1_re_o,
    output logic                              reg2_re_o,
    output logic                              stall_o,
    output logic                              id_valid_o,
    output logic [DATA_WIDTH-1:0]             inst_o,
    output logic [ADDR_WIDTH-1:0]             inst_addr_o,
    output logic [DATA_WIDTH-1:0]             op1_o,
    output logic [DATA_WIDTH-1:0]             op2_o,
    output logic                              reg_we_o,
    output logic [RADDR_WIDTH-1:0]            reg_waddr_o,
    output logic                              is_load_o,
    output logic [CNT_WIDTH-1:0]              stall_cnt_o
);

    inst_cls_e              cls;
    logic [RADDR_WIDTH-1:0] rs1;
    logic [RADDR_WIDTH-1:0] rs2;
    logic [RADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]  imm_i;
    logic [DATA_WIDTH-1:0]  imm_u;

    logic                   dec_we;
    logic                   dec_is_load;
    logic [DATA_WIDTH-1:0]  dec_inst;
    logic [RADDR_WIDTH-1:0] dec_waddr;
    logic [DATA_WIDTH-1:0]  dec_op1;
    logic [DATA_WIDTH-1:0]  dec_op2;

    logic [DATA_WIDTH-1:0]  fwd1_data;
    logic [DATA_WIDTH-1:0]  fwd2_data;
    logic                   fwd1_pend;
    logic                   fwd2_pend;

    logic                   hazard;
    logic                   load;

    assign rs1   = RADDR_WIDTH'(inst_i[19:15]);
    assign rs2   = RADDR_WIDTH'(inst_i[24:20]);
    assign rd    = RADDR_WIDTH'(inst_i[11:7]);
    assign imm_i = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_u = DATA_WIDTH'({inst_i[31:12], 12'b0});

    // Instruction class and register-file/write-back enables.
    always_comb begin
        cls         = inst_valid_i ? classify(inst_i[6:0]) : CLS_NONE;
        reg1_re_o   = READ_DISABLE;
        reg2_re_o   = READ_DISABLE;
        dec_we      = WRITE_DISABLE;
        dec_is_load = 1'b0;
        dec_inst    = DATA_WIDTH'(NOP);
        case (cls)
            CLS_I: begin
                reg1_re_o = READ_ENABLE;
                dec_we    = WRITE_ENABLE;
            end
            CLS_R: begin
                reg1_re_o = READ_ENABLE;
                reg2_re_o = READ_ENABLE;
                dec_we    = WRITE_ENABLE;
            end
            CLS_LUI, CLS_AUIPC: begin
                dec_we    = WRITE_ENABLE;
            end
            CLS_LOAD: begin
                reg1_re_o   = READ_ENABLE;
                dec_we      = WRITE_ENABLE;
                dec_is_load = 1'b1;
            end
            default: ;
        endcase
        if (cls != CLS_NONE) begin
            dec_inst = inst_i;
        end
    end

    assign reg1_raddr_o = reg1_re_o ? rs1 : '0;
    assign reg2_raddr_o = reg2_re_o ? rs2 : '0;
    assign dec_waddr    = dec_we ? rd : '0;

    id_fwd_mux #(
        .RADDR_WIDTH (RADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .FWD_STAGES  (FWD_STAGES)
    ) u_fwd1 (
        .raddr     (reg1_raddr_o),
        .re        (reg1_re_o),
        .rdata     (reg1_rdata_i),
        .fwd_we    (fwd_we_i),
        .fwd_waddr (fwd_waddr_i),
        .fwd_wdata (fwd_wdata_i),
        .fwd_pend  (fwd_pend_i),
        .data      (fwd1_data),
        .pend      (fwd1_pend)
    );

    id_fwd_mux #(
        .RADDR_WIDTH (RADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .FWD_STAGES  (FWD_STAGES)
    ) u_fwd2 (
        .raddr     (reg2_raddr_o),
        .re        (reg2_re_o),
        .rdata     (reg2_rdata_i),
        .fwd_we    (fwd_we_i),
        .fwd_waddr (fwd_waddr_i),
        .fwd_wdata (fwd_wdata_i),
        .fwd_pend  (fwd_pend_i),
        .data      (fwd2_data),
        .pend      (fwd2_pend)
    );

    always_comb begin
        dec_op1 = '0;
        dec_op2 = '0;
        case (cls)
            CLS_I, CLS_LOAD: begin
                dec_op1 = fwd1_data;
                dec_op2 = imm_i;
            end
            CLS_R: begin
                dec_op1 = fwd1_data;
                dec_op2 = fwd2_data;
            end
            CLS_LUI: begin
                dec_op1 = imm_u;
                dec_op2 = DATA_WIDTH'(ZERO);
            end
            CLS_AUIPC: begin
                dec_op1 = DATA_WIDTH'(inst_addr_i);
                dec_op2 = imm_u;
            end
            default: ;
        endcase
    end

    // Pending flags are only raised for enabled reads, which already
    // require a valid instruction; the explicit qualifier keeps intent clear.
    assign hazard  = inst_valid_i & (fwd1_pend | fwd2_pend);
    assign load    = !id_valid_o | ex_ready_i;
    assign stall_o = !flush_i & inst_valid_i & (hazard | !load);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            id_valid_o  <= 1'b0;
            inst_o      <= DATA_WIDTH'(NOP);
            inst_addr_o <= '0;
            op1_o       <= '0;
            op2_o       <= '0;
            reg_we_o    <= WRITE_DISABLE;
            reg_waddr_o <= '0;
            is_load_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (hazard && !flush_i && stall_cnt_o != {CNT_WIDTH{1'b1}}) begin
                stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
            end
            // Bubble and flush only kill the control fields; the data
            // fields are don't-care once id_valid_o drops.
            if (flush_i || (load && hazard)) begin
                id_valid_o <= 1'b0;
                inst_o     <= DATA_WIDTH'(NOP);
                reg_we_o   <= WRITE_DISABLE;
                is_load_o  <= 1'b0;
            end else if (load) begin
                id_valid_o  <= inst_valid_i;
                inst_o      <= dec_inst;
                inst_addr_o <= inst_addr_i;
                op1_o       <= dec_op1;
                op2_o       <= dec_op2;
                reg_we_o    <= dec_we;
                reg_waddr_o <= dec_waddr;
                is_load_o   <= dec_is_load;
            end
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
module tb_id_pipe;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int FS = 2;
    localparam int CW = 4;
    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_valid;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst;
    logic [DW-1:0] reg1_rdata, reg2_rdata;
    logic [FS-1:0] fwd_we, fwd_pend;
    logic [FS*RW-1:0] fwd_waddr;
    logic [FS*DW-1:0] fwd_wdata;
    logic          ex_ready, flush;

    logic [RW-1:0] raddr1, raddr2;
    logic          re1, re2, stall, id_valid;
    logic [DW-1:0] q_inst, q_op1, q_op2;
    logic [AW-1:0] q_addr;
    logic          q_we, q_load;
    logic [RW-1:0] q_waddr;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_pipe #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RADDR_WIDTH (RW),
        .FWD_STAGES (FS), .CNT_WIDTH (CW)
    ) dut (
        .clk_i (clk), .rst_n_i (rst_n), .inst_valid_i (inst_valid),
        .inst_addr_i (inst_addr), .inst_i (inst),
        .reg1_rdata_i (reg1_rdata), .reg2_rdata_i (reg2_rdata),
        .fwd_we_i (fwd_we), .fwd_waddr_i (fwd_waddr), .fwd_wdata_i (fwd_wdata),
        .fwd_pend_i (fwd_pend), .ex_ready_i (ex_ready), .flush_i (flush),
        .reg1_raddr_o (raddr1), .reg2_raddr_o (raddr2),
        .reg1_re_o (re1), .reg2_re_o (re2), .stall_o (stall),
        .id_valid_o (id_valid), .inst_o (q_inst), .inst_addr_o (q_addr),
        .op1_o (q_op1), .op2_o (q_op2), .reg_we_o (q_we),
        .reg_waddr_o (q_waddr), .is_load_o (q_load), .stall_cnt_o (stall_cnt)
    );

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_l(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_valid = 1'b0; inst = NOP_I; inst_addr = '0;
        reg1_rdata = '0; reg2_rdata = '0;
        fwd_we = '0; fwd_pend = '0; fwd_waddr = '0; fwd_wdata = '0;
        ex_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_fwd(input int k, input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic pd);
        fwd_we[k] = we;
        fwd_waddr[k*RW +: RW] = wa;
        fwd_wdata[k*DW +: DW] = wd;
        fwd_pend[k] = pd;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] pc);
        inst_valid = 1'b1; inst = i; inst_addr = pc;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        drive(enc_i(5'd3, 5'd0, 12'd7), 32'h40);
        tick(); tick();
        n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", id_valid); else n_pass++;
        n_checks++; if (q_inst !== NOP_I) $display("FAIL reset_inst got %h want %h", q_inst, NOP_I); else n_pass++;
        n_checks++; if (stall_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", stall_cnt); else n_pass++;
        n_checks++; if ({q_addr, q_op1, q_op2, q_waddr} !== '0) $display("FAIL reset_data got %h/%h/%h/%h want 0", q_addr, q_op1, q_op2, q_waddr); else n_pass++;
        n_checks++; if ({q_we, q_load} !== 2'b00) $display("FAIL reset_flags got %b want 00", {q_we, q_load}); else n_pass++;
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_decode();
        do_reset();
        drive(enc_i(5'd1, 5'd0, 12'd5), 32'h100);
        reg1_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (re1 !== 1'b1 || re2 !== 1'b0) $display("FAIL addi_re got %b%b want 10", re1, re2); else n_pass++;
        tick();
        n_checks++; if (q_op1 !== 32'd0 || q_op2 !== 32'd5) $display("FAIL addi_ops got %h/%h want 0/5", q_op1, q_op2); else n_pass++;
        n_checks++; if (q_waddr !== 5'd1 || q_we !== 1'b1 || id_valid !== 1'b1) $display("FAIL addi_wb got %0d/%b/%b want 1/1/1", q_waddr, q_we, id_valid); else n_pass++;
        n_checks++; if (q_addr !== 32'h100) $display("FAIL addi_pc got %h want 100", q_addr); else n_pass++;
        drive(enc_i(5'd4, 5'd2, 12'hFFD), 32'h104);
        reg1_rdata = 32'h100;
        tick();
        n_checks++; if (q_op1 !== 32'h100 || q_op2 !== 32'hFFFF_FFFD) $display("FAIL addi_neg got %h/%h want 100/fffffffd", q_op1, q_op2); else n_pass++;
        drive(enc_u(7'b0110111, 5'd9, 20'hABCDE), 32'h108);
        tick();
        n_checks++; if (q_op1 !== 32'hABCD_E000 || q_op2 !== 32'd0) $display("FAIL lui got %h/%h want abcde000/0", q_op1, q_op2); else n_pass++;
        drive(enc_u(7'b0010111, 5'd9, 20'h12345), 32'h400);
        tick();
        n_checks++; if (q_op1 !== 32'h400 || q_op2 !== 32'h1234_5000) $display("FAIL auipc got %h/%h want 400/12345000", q_op1, q_op2); else n_pass++;
        drive(32'h0000_007F, 32'h40C);
        tick();
        n_checks++; if (q_inst !== NOP_I || q_we !== 1'b0 || q_load !== 1'b0) $display("FAIL unknown_op got %h/%b/%b want nop/0/0", q_inst, q_we, q_load); else n_pass++;
        idle();
        tick();
        n_checks++; if (id_valid !== 1'b0) $display("FAIL invalid_in got %b want 0", id_valid); else n_pass++;
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(enc_r(5'd3, 5'd1, 5'd2), 32'h200);
        reg1_rdata = 32'h11; reg2_rdata = 32'h22;
        set_fwd(0, 1'b1, 5'd1, 32'hA, 1'b0);
        set_fwd(1, 1'b1, 5'd1, 32'hB, 1'b0);
        tick();
        n_checks++; if (q_op1 !== 32'hA || q_op2 !== 32'h22) $display("FAIL fwd_young got %h/%h want a/22", q_op1, q_op2); else n_pass++;
        fwd_we[0] = 1'b0;
        tick();
        n_checks++; if (q_op1 !== 32'hB) $display("FAIL fwd_old got %h want b", q_op1); else n_pass++;
        fwd_we = '0;
        tick();
        n_checks++; if (q_op1 !== 32'h11) $display("FAIL fwd_none got %h want 11", q_op1); else n_pass++;
        set_fwd(0, 1'b1, 5'd0, 32'hFF, 1'b0);
        drive(enc_i(5'd2, 5'd0, 12'd1), 32'h20C);
        reg1_rdata = 32'h33;
        tick();
        n_checks++; if (q_op1 !== 32'd0 || q_op2 !== 32'd1) $display("FAIL fwd_x0 got %h/%h want 0/1", q_op1, q_op2); else n_pass++;
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(enc_l(5'd5, 5'd1, 12'd8), 32'h300);
        reg1_rdata = 32'h1000;
        tick();
        n_checks++; if (q_load !== 1'b1 || q_waddr !== 5'd5 || q_op2 !== 32'd8) $display("FAIL lw_decode got %b/%0d/%h want 1/5/8", q_load, q_waddr, q_op2); else n_pass++;
        set_fwd(0, 1'b1, 5'd5, 32'h55, 1'b1);
        drive(enc_r(5'd6, 5'd5, 5'd5), 32'h304);
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else n_pass++;
        tick();
        n_checks++; if (id_valid !== 1'b0 || q_we !== 1'b0 || stall_cnt !== 4'd1) $display("FAIL lu_bubble got %b/%b/%0d want 0/0/1", id_valid, q_we, stall_cnt); else n_pass++;
        set_fwd(0, 1'b1, 5'd5, 32'h77, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL lu_release got %b want 0", stall); else n_pass++;
        tick();
        n_checks++; if (q_op1 !== 32'h77 || q_op2 !== 32'h77 || id_valid !== 1'b1) $display("FAIL lu_fwd got %h/%h/%b want 77/77/1", q_op1, q_op2, id_valid); else n_pass++;
        n_checks++; if (stall_cnt !== 4'd1) $display("FAIL lu_cnt got %0d want 1", stall_cnt); else n_pass++;
    endtask

    // Continues from test_load_use: add x6 held in ID/EX with op1=op2=0x77.
    task automatic test_backpressure();
        fwd_we = '0; fwd_pend = '0;
        ex_ready = 1'b0;
        drive(enc_i(5'd7, 5'd0, 12'd9), 32'h308);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (stall !== 1'b1) $display("FAIL bp_stall c%0d got %b want 1", c, stall); else n_pass++;
            tick();
            n_checks++; if (id_valid !== 1'b1 || q_inst !== enc_r(5'd6, 5'd5, 5'd5) || q_op1 !== 32'h77 || q_addr !== 32'h304)
                $display("FAIL bp_hold c%0d got %b/%h/%h/%h want 1/add/77/304", c, id_valid, q_inst, q_op1, q_addr); else n_pass++;
            n_checks++; if (stall_cnt !== 4'd1) $display("FAIL bp_cnt c%0d got %0d want 1", c, stall_cnt); else n_pass++;
        end
        ex_ready = 1'b1;
        tick();
        n_checks++; if (q_op2 !== 32'd9 || q_waddr !== 5'd7) $display("FAIL bp_accept got %h/%0d want 9/7", q_op2, q_waddr); else n_pass++;
        idle();
    endtask

    task automatic test_shadow();
        do_reset();
        set_fwd(0, 1'b1, 5'd5, 32'h1, 1'b1);
        set_fwd(1, 1'b1, 5'd5, 32'h2, 1'b0);
        drive(enc_r(5'd6, 5'd5, 5'd0), 32'h500);
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL shadow_stall got %b want 1", stall); else n_pass++;
        tick();
        n_checks++; if (id_valid !== 1'b0 || stall_cnt !== 4'd1) $display("FAIL shadow_bubble got %b/%0d want 0/1", id_valid, stall_cnt); else n_pass++;
        set_fwd(0, 1'b1, 5'd9, 32'h1, 1'b1);
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL shadow_other got %b want 0", stall); else n_pass++;
        tick();
        n_checks++; if (q_op1 !== 32'h2 || q_op2 !== 32'h0 || id_valid !== 1'b1) $display("FAIL shadow_op got %h/%h/%b want 2/0/1", q_op1, q_op2, id_valid); else n_pass++;
        idle();
    endtask

    task automatic test_flush_reset();
        do_reset();
        set_fwd(0, 1'b1, 5'd5, 32'h9, 1'b1);
        drive(enc_r(5'd6, 5'd5, 5'd5), 32'h600);
        flush = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else n_pass++;
        tick();
        n_checks++; if (id_valid !== 1'b0 || q_inst !== NOP_I || stall_cnt !== 4'd0) $display("FAIL flush_haz got %b/%h/%0d want 0/nop/0", id_valid, q_inst, stall_cnt); else n_pass++;
        flush = 1'b0; fwd_we = '0; fwd_pend = '0;
        drive(enc_i(5'd1, 5'd2, 12'd3), 32'h604);
        tick();
        ex_ready = 1'b0; flush = 1'b1;
        tick();
        n_checks++; if (id_valid !== 1'b0 || q_we !== 1'b0) $display("FAIL flush_hold got %b/%b want 0/0", id_valid, q_we); else n_pass++;
        flush = 1'b0; ex_ready = 1'b1;
        reg1_rdata = 32'h44;
        drive(enc_l(5'd8, 5'd2, 12'd4), 32'h608);
        tick();
        ex_ready = 1'b0;
        set_fwd(0, 1'b1, 5'd2, 32'h9, 1'b1);
        tick();
        n_checks++; if (id_valid !== 1'b1 || stall_cnt !== 4'd1) $display("FAIL pre_rst got %b/%0d want 1/1", id_valid, stall_cnt); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if (id_valid !== 1'b0 || q_inst !== NOP_I || q_we !== 1'b0 || q_load !== 1'b0 || stall_cnt !== 4'd0)
            $display("FAIL mid_rst_ctl got %b/%h/%b/%b/%0d want 0/nop/0/0/0", id_valid, q_inst, q_we, q_load, stall_cnt); else n_pass++;
        n_checks++; if ({q_addr, q_op1, q_op2, q_waddr} !== '0) $display("FAIL mid_rst_data got %h/%h/%h/%h want 0", q_addr, q_op1, q_op2, q_waddr); else n_pass++;
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_fwd(0, 1'b1, 5'd5, 32'h0, 1'b1);
        drive(enc_r(5'd6, 5'd5, 5'd5), 32'h700);
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_checks++; if (stall_cnt !== CW'((c > 15) ? 15 : c)) $display("FAIL sat c%0d got %0d want %0d", c, stall_cnt, (c > 15) ? 15 : c); else n_pass++;
        end
        idle();
    endtask

    // ------------------------------------------------------------------
    function automatic int cls_of(input logic [31:0] i);
        case (i[6:0])
            7'b0010011: return 1;
            7'b0110011: return 2;
            7'b0110111: return 3;
            7'b0010111: return 4;
            7'b0000011: return 5;
            default:    return 0;
        endcase
    endfunction

    task automatic fwd_model(input logic [4:0] ra, input logic [31:0] rf, output logic [31:0] val, output bit pd);
        bit found = 0;
        val = rf; pd = 0;
        if (ra == 5'd0) begin
            val = '0;
        end else begin
            for (int k = 0; k < FS; k++) begin
                if (!found && fwd_we[k] && fwd_waddr[k*RW +: RW] == ra) begin
                    found = 1;
                    val = fwd_wdata[k*DW +: DW];
                    pd = fwd_pend[k];
                end
            end
        end
    endtask

    task automatic test_random();
        logic        m_valid, m_we, m_load, m_known;
        logic [31:0] m_inst, m_addr, m_op1, m_op2;
        logic [4:0]  m_waddr;
        logic [3:0]  m_cnt;
        logic [31:0] v1, v2, u_imm, s_imm;
        bit          p1, p2, u1, u2, hz, ld, e_stall;
        int          cls, r;
        do_reset();
        m_valid = 0; m_we = 0; m_load = 0; m_known = 1; m_inst = NOP_I;
        m_addr = 0; m_op1 = 0; m_op2 = 0; m_waddr = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    inst = enc_i(5'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), 12'($urandom));
                2, 3:    inst = enc_r(5'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                4:       inst = enc_u(7'b0110111, 5'($urandom_range(0, 31)), 20'($urandom));
                5:       inst = enc_u(7'b0010111, 5'($urandom_range(0, 31)), 20'($urandom));
                6, 7:    inst = enc_l(5'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), 12'($urandom));
                default: inst = $urandom;
            endcase
            inst_valid = ($urandom_range(0, 7) != 0);
            inst_addr  = $urandom;
            reg1_rdata = $urandom;
            reg2_rdata = $urandom;
            for (int k = 0; k < FS; k++)
                set_fwd(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 5) == 0));
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 11) == 0);
            #1;
            cls = inst_valid ? cls_of(inst) : 0;
            u1  = (cls == 1 || cls == 2 || cls == 5);
            u2  = (cls == 2);
            fwd_model(inst[19:15], reg1_rdata, v1, p1);
            fwd_model(inst[24:20], reg2_rdata, v2, p2);
            hz  = inst_valid && ((u1 && p1) || (u2 && p2));
            ld  = !m_valid || ex_ready;
            e_stall = !flush && inst_valid && (hz || !ld);
            n_checks++; if (stall !== e_stall) $display("FAIL rnd_stall cyc %0d got %b want %b", cyc, stall, e_stall); else n_pass++;
            n_checks++; if (re1 !== u1 || re2 !== u2) $display("FAIL rnd_re cyc %0d got %b%b want %b%b", cyc, re1, re2, u1, u2); else n_pass++;
            if (u1) begin
                n_checks++; if (raddr1 !== inst[19:15]) $display("FAIL rnd_ra1 cyc %0d got %0d want %0d", cyc, raddr1, inst[19:15]); else n_pass++;
            end
            if (u2) begin
                n_checks++; if (raddr2 !== inst[24:20]) $display("FAIL rnd_ra2 cyc %0d got %0d want %0d", cyc, raddr2, inst[24:20]); else n_pass++;
            end
            if (!flush && hz && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            if (flush || (ld && hz)) begin
                m_valid = 0; m_inst = NOP_I; m_we = 0; m_load = 0; m_known = 0;
            end else if (ld) begin
                m_valid = inst_valid;
                if (cls != 0) begin
                    s_imm = {{20{inst[31]}}, inst[31:20]};
                    u_imm = {inst[31:12], 12'b0};
                    m_inst = inst; m_we = 1; m_waddr = inst[11:7];
                    m_load = (cls == 5); m_addr = inst_addr; m_known = 1;
                    case (cls)
                        1, 5:    begin m_op1 = v1;        m_op2 = s_imm; end
                        2:       begin m_op1 = v1;        m_op2 = v2;    end
                        3:       begin m_op1 = u_imm;     m_op2 = 0;     end
                        default: begin m_op1 = inst_addr; m_op2 = u_imm; end
                    endcase
                end else begin
                    m_inst = NOP_I; m_we = 0; m_load = 0; m_known = 0;
                end
            end
            tick();
            n_checks++; if (id_valid !== m_valid || q_we !== m_we || q_load !== m_load)
                $display("FAIL rnd_ctl cyc %0d got %b%b%b want %b%b%b", cyc, id_valid, q_we, q_load, m_valid, m_we, m_load); else n_pass++;
            n_checks++; if (q_inst !== m_inst) $display("FAIL rnd_inst cyc %0d got %h want %h", cyc, q_inst, m_inst); else n_pass++;
            n_checks++; if (stall_cnt !== m_cnt) $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, stall_cnt, m_cnt); else n_pass++;
            if (m_known) begin
                n_checks++; if (q_op1 !== m_op1 || q_op2 !== m_op2 || q_addr !== m_addr || q_waddr !== m_waddr)
                    $display("FAIL rnd_data cyc %0d got %h/%h/%h/%0d want %h/%h/%h/%0d", cyc, q_op1, q_op2, q_addr, q_waddr, m_op1, m_op2, m_addr, m_waddr); else n_pass++;
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_decode();
        test_forwarding();
        test_load_use();
        test_backpressure();
        test_shadow();
        test_flush_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
